// File: rtl/ifetch_req_unit.sv
// Instruction-fetch request generator: issues word-aligned imem requests, tracks outstanding
// tags and forwards responses to fifo_unit. Optional bus-error reporting under `IFETCH_ERR_EN.
module ifetch_req_unit #(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = 32'h1000_0000,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_addr_i,
  input  logic            fifo_ready_i,
  output logic            fifo_clear_o,
  output logic [XLEN-1:0] out_addr_o,
  output logic [XLEN-1:0] out_instr_o,
  output logic            out_valid_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i
`ifdef IFETCH_ERR_EN
  ,
  input  logic            imem_err_i,
  output logic            out_err_o
`endif
);

  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

  typedef enum logic {IDLE, REQ} state_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            kill;
  } tag_t;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] held_q, held_d;
  logic            pend_kill_q, pend_kill_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  tag_t            tag_q [MAX_OUTSTANDING];
  tag_t            tag_d [MAX_OUTSTANDING];

  tag_t            head;
  logic [XLEN-1:0] req_pc;
  logic            gnt_acc;
  logic            halt_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // A request caught by a redirect before its grant keeps its original address in held_q.
  assign req_pc      = pend_kill_q ? held_q : pc_q;
  assign imem_req_o  = (state_q == REQ);
  assign imem_addr_o = {req_pc[XLEN-1:2], 2'b00};
  assign gnt_acc     = imem_req_o & imem_gnt_i;

  assign head         = tag_q[rd_ptr_q];
  assign out_valid_o  = imem_rvalid_i & ~head.kill & ~redirect_i;
  assign out_addr_o   = head.addr;
  assign out_instr_o  = imem_rdata_i;
  assign fifo_clear_o = redirect_i;

`ifdef IFETCH_ERR_EN
  logic halt_q, halt_d;

  assign out_err_o = imem_rvalid_i & imem_err_i & ~head.kill & ~redirect_i;
  assign halt_d    = redirect_i ? 1'b0 : (halt_q | out_err_o);
  assign halt_next = halt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) halt_q <= 1'b0;
    else         halt_q <= halt_d;
  end
`else
  assign halt_next = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through this block infers a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    held_d      = held_q;
    pend_kill_d = pend_kill_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    tag_d       = tag_q;
    cnt_d       = cnt_q;

    unique case ({gnt_acc, imem_rvalid_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (imem_rvalid_i) rd_ptr_d = ptr_inc(rd_ptr_q);

    if (redirect_i) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) tag_d[i].kill = 1'b1;
    end

    if (gnt_acc) begin
      tag_d[wr_ptr_q] = '{addr: req_pc, kill: redirect_i | pend_kill_q};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
      pc_d            = pend_kill_q ? pc_q : ({pc_q[XLEN-1:2], 2'b00} + XLEN'(4));
      pend_kill_d     = 1'b0;
    end

    // The newest redirect target always wins; the in-flight address is captured only once.
    if (redirect_i) begin
      pc_d = redirect_addr_i;
      if (imem_req_o && !imem_gnt_i) begin
        pend_kill_d = 1'b1;
        if (!pend_kill_q) held_d = pc_q;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (fifo_ready_i && (cnt_q < MAX_CNT) && !redirect_i && !halt_next) state_d = REQ;
      end
      REQ: begin
        if (gnt_acc && !((cnt_d < MAX_CNT) && fifo_ready_i && !halt_next)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      held_q      <= '0;
      pend_kill_q <= 1'b0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      // NOTE: the tag store is reset because its head drives out_addr_o and the kill gating.
      for (int i = 0; i < MAX_OUTSTANDING; i++) tag_q[i] <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q     <= state_d;
      pc_q        <= pc_d;
      held_q      <= held_d;
      pend_kill_q <= pend_kill_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tag_q       <= tag_d;
    end
  end

  a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem_rvalid_i |-> (cnt_q != '0));

  a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= MAX_CNT);

endmodule
